// File: rtl/systolic_drain_if.sv
// Result port of systolic_drain: FIFO head on a valid/ready handshake,
// plus the credit and status signals the issuing logic watches.
interface systolic_drain_if #(
   parameter int data_size  = 8,
   parameter int size       = 3,
   parameter int fifo_depth = 4
);
   logic [data_size*size-1:0]    out_vec;
   logic                         out_valid;
   logic                         out_ready;
   logic                         credit_ok;
   logic [$clog2(fifo_depth):0]  fifo_count;
   logic                         overflow;

   modport master (
      output out_vec,
      output out_valid,
      output credit_ok,
      output fifo_count,
      output overflow,
      input  out_ready
   );

   modport slave (
      input  out_vec,
      input  out_valid,
      input  credit_ok,
      input  fifo_count,
      input  overflow,
      output out_ready
   );
endinterface

// File: rtl/systolic_drain.sv
// Realigns the column-skewed y_stream of the systolic array into whole result
// vectors, queues them in a small FIFO and issues credit back to the issuer.
module systolic_drain #(
   parameter int data_size  = 8,
   parameter int size       = 3,
   parameter int fifo_depth = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [data_size*size-1:0]  y_stream,
   input  logic                       issue,
   input  logic                       flush,
   systolic_drain_if.master           res
);
   localparam int vec_w = data_size * size;
   localparam int vsr_w = 2 * size;
   localparam int aw    = $clog2(fifo_depth);
   localparam int cw    = aw + 1;
   localparam int fw    = $clog2(vsr_w + 1);
   localparam int sw    = ((cw > fw) ? cw : fw) + 1;

   logic [vsr_w-1:0] valid_sr;
   logic [vec_w-1:0] aligned;
   logic [vec_w-1:0] mem [fifo_depth];
   logic [aw-1:0]    wr_ptr;
   logic [aw-1:0]    rd_ptr;
   logic [cw-1:0]    count;
   logic             ovf;
   logic [fw-1:0]    in_flight;
   logic [sw-1:0]    committed;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             accept;

   // Column c is captured size+c edges after issue and then delayed so that
   // every column lands in its last stage on the same edge (E + 2*size - 1).
   for (genvar c = 0; c < size; c++) begin : g_col
      localparam int stages = size - c;
      logic [data_size-1:0] stage [stages];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 0; k < stages; k++) begin
               stage[k] <= '0;
            end
         end else begin
            stage[0] <= y_stream[(size-c)*data_size-1 -: data_size];
            for (int k = 1; k < stages; k++) begin
               stage[k] <= stage[k-1];
            end
         end
      end

      assign aligned[(size-c)*data_size-1 -: data_size] = stage[stages-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_sr <= '0;
      end else if (flush) begin
         valid_sr <= '0;
      end else begin
         valid_sr <= {valid_sr[vsr_w-2:0], issue};
      end
   end

   assign full   = (count == cw'(fifo_depth));
   assign empty  = (count == '0);
   assign push   = valid_sr[vsr_w-1];
   assign pop    = !empty && res.out_ready;
   // A full FIFO still takes the new vector when the head leaves on the same edge.
   assign accept = push && (!full || pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (accept && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !accept) begin
            count <= count - 1'b1;
         end
         if (push && !accept) begin
            ovf <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !flush) begin
         mem[wr_ptr] <= aligned;
      end
   end

   always_comb begin
      in_flight = '0;
      for (int k = 0; k < vsr_w; k++) begin
         in_flight = in_flight + fw'(valid_sr[k]);
      end
   end

   // Vectors still in the pipe already own a FIFO slot for credit purposes.
   assign committed = sw'(count) + sw'(in_flight);

   assign res.out_vec    = empty ? '0 : mem[rd_ptr];
   assign res.out_valid  = !empty;
   assign res.credit_ok  = (committed < sw'(fifo_depth));
   assign res.fifo_count = count;
   assign res.overflow   = ovf;
endmodule
